// File: rtl/test_pattern_sequencer_pkg.sv
// test_pattern_sequencer_pkg: pattern codes, sequencer state encodings and pattern wrap helper
//   Shared by the test pattern sequencer and the frame-synchronous blocks around the generator.
package test_pattern_sequencer_pkg;
   localparam logic [3:0] PAT_OFF     = 4'd0;
   localparam logic [3:0] PAT_RED     = 4'd1;
   localparam logic [3:0] PAT_GRN     = 4'd2;
   localparam logic [3:0] PAT_BLU     = 4'd3;
   localparam logic [3:0] PAT_CHECKER = 4'd4;
   localparam logic [3:0] PAT_BARS    = 4'd5;
   localparam logic [3:0] PAT_BORDER  = 4'd6;
   localparam logic [1:0] ST_DISABLED = 2'd0;
   localparam logic [1:0] ST_AUTO     = 2'd1;
   localparam logic [1:0] ST_MANUAL   = 2'd2;
   // Wrap by explicit compare against the range top, never by 4-bit overflow.
   function automatic logic [3:0] pattern_next(input logic [3:0] cur, input logic [3:0] first, input logic [3:0] last);
      return (cur == last) ? first : cur + 4'd1;
   endfunction
endpackage

// File: rtl/test_pattern_sequencer_frame_edge_detect.sv
// frame_edge_detect: one-cycle frame boundary pulse from a VSync edge
//   i_Clk, i_Rst (async, active high), i_VSync (synchronous to i_Clk),
//   o_Boundary high in the cycle where i_VSync differs from its registered copy in the VSYNC_POL direction.
module frame_edge_detect #(
   parameter bit VSYNC_POL = 1'b1
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_VSync,
   output logic o_Boundary
);
   logic vsync_q;
   always_ff @(posedge i_Clk or posedge i_Rst)
      if (i_Rst) vsync_q <= ~VSYNC_POL;
      else       vsync_q <= i_VSync;
   assign o_Boundary = VSYNC_POL ? (i_VSync & ~vsync_q) : (~i_VSync & vsync_q);
endmodule

// File: rtl/test_pattern_sequencer.sv
// test_pattern_sequencer: frame-synchronous pattern select controller for the test pattern generator
//   i_Clk, i_Rst (async, active high), i_Enable, i_Auto, i_VSync, i_Next,
//   i_Req_Valid/i_Req_Pattern/o_Req_Ready request handshake, o_Req_Error on out-of-range request,
//   o_Pattern to the generator, o_Frame_Strobe one cycle after each boundary, o_Dwell_Count for debug.
module test_pattern_sequencer
   import test_pattern_sequencer_pkg::*;
#(
   parameter int PATTERN_FIRST = 1,
   parameter int PATTERN_LAST  = 6,
   parameter int DWELL_FRAMES  = 120,
   parameter int DWELL_WIDTH   = 8,
   parameter bit VSYNC_POL     = 1'b1
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst,
   input  logic                   i_Enable,
   input  logic                   i_Auto,
   input  logic                   i_VSync,
   input  logic                   i_Next,
   input  logic                   i_Req_Valid,
   input  logic [3:0]             i_Req_Pattern,
   output logic                   o_Req_Ready,
   output logic                   o_Req_Error,
   output logic [3:0]             o_Pattern,
   output logic                   o_Frame_Strobe,
   output logic [DWELL_WIDTH-1:0] o_Dwell_Count
);
   localparam logic [3:0] P_FIRST = 4'(PATTERN_FIRST);
   localparam logic [3:0] P_LAST  = 4'(PATTERN_LAST);
   localparam logic [DWELL_WIDTH-1:0] DWELL_LAST = DWELL_WIDTH'(DWELL_FRAMES - 1);
   logic [1:0]             state;
   logic [3:0]             pattern;
   logic [3:0]             pend_pat;
   logic                   pend_valid;
   logic [DWELL_WIDTH-1:0] dwell;
   logic                   req_error;
   logic                   frame_strobe;
   logic                   boundary;
   logic                   ready;
   logic                   xfer;
   logic                   in_range;
   logic [1:0]             mode;
   logic                   disabling;
   frame_edge_detect #(.VSYNC_POL(VSYNC_POL)) u_edge (
      .i_Clk      (i_Clk),
      .i_Rst      (i_Rst),
      .i_VSync    (i_VSync),
      .o_Boundary (boundary)
   );
   assign ready     = (state != ST_DISABLED) && !pend_valid;
   assign xfer      = i_Req_Valid && ready;
   assign in_range  = (i_Req_Pattern >= P_FIRST) && (i_Req_Pattern <= P_LAST);
   assign mode      = i_Auto ? ST_AUTO : ST_MANUAL;
   assign disabling = boundary && !i_Enable && (state != ST_DISABLED);
   always_ff @(posedge i_Clk or posedge i_Rst)
      if (i_Rst) begin
         state        <= ST_DISABLED;
         pattern      <= PAT_OFF;
         pend_pat     <= PAT_OFF;
         pend_valid   <= 1'b0;
         dwell        <= '0;
         req_error    <= 1'b0;
         frame_strobe <= 1'b0;
      end else begin
         frame_strobe <= boundary;
         req_error    <= xfer && !in_range;
         // A transfer in the boundary cycle only sets pending; application reads the old pending flag.
         if (xfer && in_range) begin
            pend_valid <= 1'b1;
            pend_pat   <= i_Req_Pattern;
         end else if (i_Next && state == ST_MANUAL && !pend_valid) begin
            pend_valid <= 1'b1;
            pend_pat   <= pattern_next(pattern, P_FIRST, P_LAST);
         end
         if (boundary) begin
            if (state == ST_DISABLED) begin
               if (i_Enable) begin
                  state   <= mode;
                  pattern <= P_FIRST;
                  dwell   <= '0;
               end
            end else if (!i_Enable) begin
               state      <= ST_DISABLED;
               pattern    <= PAT_OFF;
               pend_valid <= 1'b0;
               dwell      <= '0;
            end else if (pend_valid) begin
               pattern    <= pend_pat;
               pend_valid <= 1'b0;
               dwell      <= '0;
            end else if (state == ST_AUTO) begin
               if (dwell == DWELL_LAST) begin
                  pattern <= pattern_next(pattern, P_FIRST, P_LAST);
                  dwell   <= '0;
               end else begin
                  dwell <= dwell + DWELL_WIDTH'(1);
               end
            end
         end
         // Mode follows i_Auto immediately, but a disable at this boundary takes precedence.
         if (state != ST_DISABLED && mode != state && !disabling) begin
            state <= mode;
            dwell <= '0;
         end
      end
   assign o_Req_Ready    = ready;
   assign o_Req_Error    = req_error;
   assign o_Pattern      = pattern;
   assign o_Frame_Strobe = frame_strobe;
   assign o_Dwell_Count  = dwell;
endmodule

// File: tb/tb_test_pattern_sequencer.sv
// tb_test_pattern_sequencer: directed self-checking bench, dwell 2 (a) and dwell 1 (b) instances
module tb_test_pattern_sequencer;
   logic       i_Clk = 1'b0;
   logic       i_Rst, i_Enable, i_Auto, i_VSync, i_Next, i_Req_Valid;
   logic [3:0] i_Req_Pattern;
   logic       ready_a, err_a, strobe_a, ready_b, err_b, strobe_b;
   logic [3:0] pat_a, pat_b;
   logic [7:0] dwell_a, dwell_b;
   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] exp_a [6] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
   logic [7:0] exp_d [6] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
   always #5 i_Clk = ~i_Clk;
   test_pattern_sequencer #(.DWELL_FRAMES(2)) u_dut_a (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable), .i_Auto(i_Auto), .i_VSync(i_VSync),
      .i_Next(i_Next), .i_Req_Valid(i_Req_Valid), .i_Req_Pattern(i_Req_Pattern),
      .o_Req_Ready(ready_a), .o_Req_Error(err_a), .o_Pattern(pat_a),
      .o_Frame_Strobe(strobe_a), .o_Dwell_Count(dwell_a)
   );
   test_pattern_sequencer #(.DWELL_FRAMES(1)) u_dut_b (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable), .i_Auto(i_Auto), .i_VSync(i_VSync),
      .i_Next(i_Next), .i_Req_Valid(i_Req_Valid), .i_Req_Pattern(i_Req_Pattern),
      .o_Req_Ready(ready_b), .o_Req_Error(err_b), .o_Pattern(pat_b),
      .o_Frame_Strobe(strobe_b), .o_Dwell_Count(dwell_b)
   );
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask
   // Edge in the cycle i_VSync is high; on return we sit in the following cycle.
   task automatic vsync();
      i_VSync = 1'b1;
      tick();
      i_VSync = 1'b0;
   endtask
   task automatic request(input logic [3:0] code);
      i_Req_Valid   = 1'b1;
      i_Req_Pattern = code;
      tick();
      i_Req_Valid   = 1'b0;
   endtask
   initial begin
      i_Rst = 1'b1; i_Enable = 1'b0; i_Auto = 1'b0; i_VSync = 1'b0;
      i_Next = 1'b0; i_Req_Valid = 1'b0; i_Req_Pattern = 4'd0;
      tick(); tick();
      chk("rst_pattern", pat_a, 0);
      chk("rst_ready", ready_a, 0);
      chk("rst_error", err_a, 0);
      chk("rst_strobe", strobe_a, 0);
      chk("rst_dwell", dwell_a, 0);
      i_Rst = 1'b0;
      tick();
      i_Enable = 1'b1; i_Auto = 1'b1;
      tick();
      chk("disabled_ready", ready_a, 0);
      for (int i = 0; i < 6; i++) begin
         vsync();
         chk("auto_strobe", strobe_a, 1);
         chk("auto_pattern_a", pat_a, exp_a[i]);
         chk("auto_dwell_a", dwell_a, exp_d[i]);
         chk("auto_pattern_b", pat_b, 8'(i + 1));
         chk("auto_dwell_b", dwell_b, 0);
         tick();
         chk("auto_strobe_low", strobe_a, 0);
         tick();
      end
      vsync();
      chk("auto7_pattern_a", pat_a, 4);
      chk("wrap_pattern_b", pat_b, 1);
      chk("wrap_dwell_b", dwell_b, 0);
      tick();
      vsync();
      chk("auto8_dwell_a", dwell_a, 1);
      chk("auto8_pattern_b", pat_b, 2);
      tick();
      i_Auto = 1'b0;
      tick();
      chk("manual_dwell_clear", dwell_a, 0);
      chk("manual_pattern_kept", pat_a, 4);
      chk("manual_ready", ready_a, 1);
      request(4'd5);
      chk("req5_ready_drop", ready_a, 0);
      chk("req5_no_error", err_a, 0);
      request(4'd2);
      chk("req2_refused_ready", ready_a, 0);
      chk("req5_not_early", pat_a, 4);
      tick();
      vsync();
      chk("req5_applied_a", pat_a, 5);
      chk("req5_applied_b", pat_b, 5);
      chk("req5_strobe", strobe_a, 1);
      tick();
      chk("req5_ready_back", ready_a, 1);
      vsync();
      chk("req2_discarded", pat_a, 5);
      tick();
      request(4'd9);
      chk("req9_error", err_a, 1);
      chk("req9_ready", ready_a, 1);
      tick();
      chk("req9_error_pulse", err_a, 0);
      request(4'd0);
      chk("req0_error", err_a, 1);
      chk("req0_ready", ready_a, 1);
      tick();
      vsync();
      chk("bad_req_pattern", pat_a, 5);
      tick();
      i_Next = 1'b1;
      tick();
      i_Next = 1'b0;
      chk("next_pending", ready_a, 0);
      vsync();
      chk("next_to_6", pat_a, 6);
      tick();
      i_Next = 1'b1;
      request(4'd3);
      i_Next = 1'b0;
      vsync();
      chk("req_beats_next", pat_a, 3);
      tick();
      i_VSync = 1'b1;
      request(4'd2);
      i_VSync = 1'b0;
      chk("same_cycle_strobe", strobe_a, 1);
      chk("same_cycle_not_applied", pat_a, 3);
      chk("same_cycle_pending", ready_a, 0);
      tick();
      vsync();
      chk("same_cycle_later", pat_a, 2);
      tick();
      request(4'd6);
      vsync();
      tick();
      i_Next = 1'b1;
      tick();
      i_Next = 1'b0;
      vsync();
      chk("next_wrap", pat_a, 1);
      tick();
      request(4'd4);
      i_Enable = 1'b0;
      vsync();
      chk("disable_pattern", pat_a, 0);
      chk("disable_ready", ready_a, 0);
      tick();
      i_Enable = 1'b1;
      vsync();
      chk("reenable_first", pat_a, 1);
      chk("reenable_ready", ready_a, 1);
      tick();
      request(4'd5);
      chk("pre_rst_pending", ready_a, 0);
      #3;
      i_Rst = 1'b1;
      #1;
      chk("async_rst_pattern", pat_a, 0);
      chk("async_rst_ready", ready_a, 0);
      chk("async_rst_error", err_a, 0);
      chk("async_rst_strobe", strobe_a, 0);
      chk("async_rst_pattern_b", pat_b, 0);
      i_Enable = 1'b0;
      @(negedge i_Clk);
      i_Rst = 1'b0;
      tick();
      vsync();
      chk("post_rst_pattern", pat_a, 0);
      chk("post_rst_strobe", strobe_a, 1);
      chk("post_rst_ready", ready_a, 0);
      tick();
      i_Enable = 1'b1;
      vsync();
      chk("post_rst_enable", pat_a, 1);
      chk("post_rst_pending_clear", ready_a, 1);
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/test_pattern_sequencer.md
Name: test_pattern_sequencer

Overview:
Controller that drives the 4-bit pattern-select input of the test pattern generator. Supports three modes: disabled, auto-cycle through a pattern range every N frames, and manual selection by next-pulse or valid/ready request. All pattern changes are applied only at a frame boundary (VSync edge), so no frame shows two patterns. Sits between board controls/host register logic and the pattern generator, on the same pixel clock.

Parameters:
PATTERN_FIRST, 1, lowest pattern code in the cycle range (0 = generator off).
PATTERN_LAST, 6, highest pattern code in the cycle range; wrap point.
DWELL_FRAMES, 120, frames each pattern is shown in auto mode; legal range 1..2^DWELL_WIDTH.
DWELL_WIDTH, 8, width of the dwell frame counter.
VSYNC_POL, 1, frame boundary edge: 1 = i_VSync 0->1, 0 = i_VSync 1->0.

Ports:
i_Clk  in  1  pixel clock.
i_Rst  in  1  asynchronous active-high reset.
i_Enable  in  1  level; 1 = sequencer drives non-zero patterns.
i_Auto  in  1  level; 1 = auto-cycle mode, 0 = manual mode.
i_VSync  in  1  vertical sync from the timing source, synchronous to i_Clk.
i_Next  in  1  single-cycle pulse; manual mode advances to the next pattern.
i_Req_Valid  in  1  explicit pattern request valid.
i_Req_Pattern  in  4  requested pattern code.
o_Req_Ready  out  1  request can be accepted this cycle.
o_Req_Error  out  1  one-cycle pulse; accepted request was out of range and discarded.
o_Pattern  out  4  pattern select to the generator.
o_Frame_Strobe  out  1  one-cycle pulse in the cycle o_Pattern may change.
o_Dwell_Count  out  DWELL_WIDTH  current dwell frame count, for debug.

Behaviour:
- Reset (async, i_Rst=1): state DISABLED, o_Pattern=0, o_Req_Ready=0, o_Req_Error=0, o_Frame_Strobe=0, o_Dwell_Count=0, pending flag clear, VSync history register = inactive level.
- Frame boundary: the configured edge between the registered i_VSync (previous cycle) and the current i_VSync.
  - Edge present in cycle N: o_Frame_Strobe=1 and any o_Pattern update both appear in cycle N+1.
  - Latency is exactly 1 clock.
- States:
  - DISABLED: o_Pattern=0 and requests are refused (ready=0). At the first boundary with i_Enable=1, go to AUTO or MANUAL per i_Auto, set o_Pattern=PATTERN_FIRST and dwell=0.
  - AUTO:
    - dwell increments on each boundary.
    - At a boundary with dwell==DWELL_FRAMES-1: o_Pattern advances (PATTERN_LAST wraps to PATTERN_FIRST) and dwell=0.
    - i_Next is ignored.
  - MANUAL: dwell is held at 0. An i_Next pulse sets pending = o_Pattern+1 with wrap, unless a request is already pending, in which case the pulse is dropped.
  - AUTO<->MANUAL: follows i_Auto on the next clock without waiting for a frame; o_Pattern is retained, dwell is cleared, pending is retained.
  - i_Enable falling in AUTO/MANUAL: at the next boundary o_Pattern=0, pending is cleared, state goes to DISABLED.
- Request handshake:
  - o_Req_Ready = (state!=DISABLED) && !pending.
  - Transfer happens when i_Req_Valid && o_Req_Ready.
  - In-range code (PATTERN_FIRST..PATTERN_LAST): latched into pending and ready drops the next cycle.
  - Out-of-range code: no pending is created and o_Req_Error pulses in the next cycle.
- Pending application: at the next boundary, o_Pattern=pending and pending is cleared; in AUTO, dwell is also reset to 0. Ready returns the cycle after.
  - If the transfer and a boundary occur in the same cycle, the request is applied at the following boundary, not the current one.
- Simultaneous events:
  - Request transfer and i_Next in the same cycle: the request wins and i_Next is dropped.
  - Pending and auto-advance due at the same boundary: pending wins.
  - Disable and pending at the same boundary: disable wins and pending is discarded.
- Arithmetic:
  - Pattern increment uses a 4-bit compare against PATTERN_LAST, never natural 4-bit overflow.
  - The dwell compare uses DWELL_WIDTH bits; DWELL_FRAMES=1 advances on every boundary.
- Reset asserted mid-frame or with a request pending: all state returns to reset values immediately, with no partial update.

Decomposition:
- Shared video package/header: pattern code constants (PAT_OFF=0, PAT_RED=1, PAT_GRN=2, PAT_BLU=3, PAT_CHECKER=4, PAT_BARS=5, PAT_BORDER=6) and sequencer state encodings (DISABLED, AUTO, MANUAL).
- One sub-module: frame_edge_detect (VSYNC_POL parameter; registered history; one-cycle boundary pulse; async active-high reset). It is reusable by other frame-synchronous controllers.

Test Plan:
- Reset, then i_Enable=1, i_Auto=1, DWELL_FRAMES=2, pulse VSync 6 times -> o_Pattern 1,1,2,2,3,3 after successive boundaries; o_Frame_Strobe one cycle after each edge.
- Auto wrap, DWELL_FRAMES=1, starting at pattern 6 -> next boundary gives o_Pattern=1, dwell stays 0.
- Manual mode, request code 5 mid-frame -> ready drops next cycle; o_Pattern=5 one cycle after the next VSync edge; ready high the cycle after that. A second request while pending is not accepted.
- Manual mode, request code 9 -> o_Req_Error pulses once, o_Pattern unchanged, ready stays 1. Request code 0 behaves the same.
- Manual mode, i_Next and a valid request (code 3) in the same cycle, current pattern 6 -> next boundary gives o_Pattern=3, not 1.
- Disable with a request pending, then assert i_Rst mid-frame -> next boundary gives o_Pattern=0 and pending cleared. i_Rst forces all outputs to reset values asynchronously, without a clock edge.
